// File: rtl/avion_pkg.sv
// avion_pkg: shared widths, port indices and arbiter state encoding for the avion memory arbiter
package avion_pkg;
  localparam int AVION_ADDR_W = 6;
  localparam int AVION_DATA_W = 10;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_HOST = 1'b1;
  typedef enum logic {ARB_FREE, ARB_LOCKED} arb_state_e;
endpackage

// File: rtl/avion_rr_pick.sv
// avion_rr_pick: 2-way round-robin picker; the port not granted last wins a tie
module avion_rr_pick (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_gnt,
  output logic [1:0] gnt
);
  always_comb begin
    gnt[0] = req0 && (!req1 || last_gnt);
    gnt[1] = req1 && (!req0 || !last_gnt);
  end
endmodule

// File: rtl/avion_mem_arbiter.sv
// avion_mem_arbiter: round-robin share of a single-port RAM between CPU and host loader
// Define AVION_ARB_LOCK_EN to add lock0/lock1 for atomic read-modify-write ownership.
module avion_mem_arbiter
  import avion_pkg::*;
#(
  parameter int ADDRESS_WIDTH = AVION_ADDR_W,
  parameter int DATA_WIDTH = AVION_DATA_W,
  parameter int CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic                     we0,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  output logic                     gnt0,
  output logic                     rvalid0,
  input  logic                     req1,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     gnt1,
  output logic                     rvalid1,
`ifdef AVION_ARB_LOCK_EN
  input  logic                     lock0,
  input  logic                     lock1,
`endif
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rdata,
  output logic [CNT_WIDTH-1:0]     contention_cnt
);
  logic       last_gnt, rd_pend0, rd_pend1, elig0, elig1;
  logic [1:0] pick;
`ifdef AVION_ARB_LOCK_EN
  arb_state_e state, state_nx;
  logic       owner, owner_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_FREE;
      owner <= PORT_CPU;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
    end
  end
  // while locked every grant belongs to the owner, so its lock bit alone decides the next state
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    if (gnt0 || gnt1) begin
      state_nx = (gnt0 ? lock0 : lock1) ? ARB_LOCKED : ARB_FREE;
      owner_nx = gnt1 ? PORT_HOST : PORT_CPU;
    end
  end
  assign elig0 = req0 && !(state == ARB_LOCKED && owner != PORT_CPU);
  assign elig1 = req1 && !(state == ARB_LOCKED && owner != PORT_HOST);
`else
  assign elig0 = req0;
  assign elig1 = req1;
`endif
  avion_rr_pick u_pick (.req0(elig0), .req1(elig1), .last_gnt(last_gnt), .gnt(pick));
  always_comb begin
    gnt0 = !rst && pick[0];
    gnt1 = !rst && pick[1];
    ram_we = gnt0 ? we0 : gnt1 && we1;
    ram_addr = gnt0 ? addr0 : gnt1 ? addr1 : '0;
    ram_wdata = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
    rdata = ram_rdata;
    rvalid0 = rd_pend0 && !rst;
    rvalid1 = rd_pend1 && !rst;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
      rd_pend0 <= 1'b0;
      rd_pend1 <= 1'b0;
      contention_cnt <= '0;
    end else begin
      if (gnt0 || gnt1) last_gnt <= gnt1;
      rd_pend0 <= gnt0 && !we0;
      rd_pend1 <= gnt1 && !we1;
      if (req0 && req1 && !(&contention_cnt)) contention_cnt <= contention_cnt + 1'b1;
    end
  end
endmodule

// File: doc/avion_mem_arbiter.md
Name: avion_mem_arbiter

Overview:
- Shares the single-port block RAM between two requesters: port 0 = avion CPU, port 1 = host/debug loader (program load, memory dump).
- Round-robin arbitration with a valid/grant handshake and in-order read-return tracking.
- Sits between the requesters and the RAM.
- RAM model: synchronous write, registered read with 1-cycle latency.

Parameters:
- ADDRESS_WIDTH, 6, RAM address width.
- DATA_WIDTH, 10, RAM word width.
- CNT_WIDTH, 8, width of the saturating contention counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req0  in  1  port 0 access request; held until gnt0.
- we0  in  1  port 0 write enable, qualified by req0.
- addr0  in  ADDRESS_WIDTH  port 0 address.
- wdata0  in  DATA_WIDTH  port 0 write data.
- gnt0  out  1  port 0 access accepted this cycle.
- rvalid0  out  1  port 0 read data valid.
- req1, we1, addr1, wdata1, gnt1, rvalid1: same as port 0, for port 1.
- rdata  out  DATA_WIDTH  read data, shared by both ports and qualified by rvalid0/rvalid1.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDRESS_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM registered read output.
- contention_cnt  out  CNT_WIDTH  number of cycles in which both ports requested.

Behaviour:
- Grant logic is combinational in the request cycle. At most one of gnt0/gnt1 is high in any cycle. gnt is only asserted when the matching req is high.
- RAM bus in a granted cycle:
  - ram_addr, ram_we and ram_wdata are driven from the granted port in the same cycle.
  - With no grant: ram_we=0, ram_addr=0, ram_wdata=0.
- Arbitration:
  - Single requester: granted immediately.
  - Both requesting: the port not granted last (last_gnt register) wins.
  - last_gnt updates only on a grant.
  - One grant per cycle; back-to-back grants allowed every cycle.
- Read return:
  - A granted read (we=0) asserts the matching rvalid for exactly one cycle, in the following cycle.
  - rdata = ram_rdata in that cycle. rdata is pass-through of ram_rdata; consumers use it only when an rvalid is high.
  - Writes produce no rvalid.
  - Issue-side state is one flop per port: rd_pend0/rd_pend1.
- Write-then-read to the same address in consecutive grants returns the new data. The RAM guarantees this because the write commits at the edge before the read samples.
- Contention counter: contention_cnt increments by 1 in each cycle with req0 && req1. It saturates at all-ones and does not wrap.
- Reset (synchronous) behaviour:
  - While rst=1: gnt0=gnt1=0, ram_we=0.
  - On the reset edge: rvalid0=rvalid1=0, last_gnt=1 (so port 0 wins the first tie), contention_cnt=0.
  - A read granted in the cycle before rst rises is dropped; no rvalid follows.
- Request drop: a requester deasserting req before gnt is legal; no access occurs.
- Address width: addresses are used as-is (ADDRESS_WIDTH bits); there is no bounds checking.

Optional Feature:
- Macro: AVION_ARB_LOCK_EN.
- With the macro defined:
  - Adds inputs lock0 and lock1 (1 bit each).
  - A grant to port N while lockN=1 sets a locked state owned by port N.
  - While locked, only the owner can be granted, regardless of round-robin order.
  - Lock releases on the first owner grant with lockN=0, or on rst.
  - Contention still counts.
  - Purpose: atomic read-modify-write for the loader.
- Without the macro: no lock ports and no locked state; pure round-robin.

Decomposition:
- Package avion_pkg holds:
  - AVION_ADDR_W=6 and AVION_DATA_W=10.
  - Port index constants PORT_CPU=0 and PORT_HOST=1.
  - Enum arb_state_e {ARB_FREE, ARB_LOCKED}.
- One natural sub-module: avion_rr_pick. It is a 2-way round-robin picker taking req0, req1 and last_gnt, and producing a one-hot grant. It is purely combinational.
- Pointer, lock FSM, rvalid pipeline and counter stay in the top.

Test Plan:
- Port 0 alone, read addr 50 (RAM holds 5): gnt0 in cycle N, then rvalid0=1 and rdata=5 in N+1. gnt1 and rvalid1 stay 0.
- Both ports request reads of 50 and 51 (values 5 and 0xA) continuously from reset:
  - Grants alternate 0,1,0,1.
  - rvalid values alternate 5, A.
  - contention_cnt increments every cycle.
- Port 1 writes 0x32 to 0, then port 0 reads 0 on the next cycle: rvalid0 returns 0x32. ram_we is high only in the write grant cycle.
- Both ports request for 300 cycles: contention_cnt saturates at 255 and stays there.
- rst asserted one cycle after a port 0 read grant:
  - No rvalid0 follows.
  - All outputs are 0.
  - After release, the first tie goes to port 0.
- With AVION_ARB_LOCK_EN: port 1 is granted with lock1=1 while port 0 requests continuously. Port 1 keeps every grant until it issues with lock1=0; port 0 is granted in the next cycle.
